// File: rtl/delay_line_ctrl_if.sv
// RAM-side bus between the delay-line controller (master) and a 1W/1R sync RAM (slave).
// The read port has a 1-cycle registered read latency.
interface delay_line_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned DATA_WIDTH    = 8
);
  logic                     ram_wr;
  logic                     ram_rd;
  logic [ADDRESS_WIDTH-1:0] ram_wr_addr;
  logic [ADDRESS_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0]    ram_din;
  logic [DATA_WIDTH-1:0]    ram_dout;

  modport master (
    output ram_wr, ram_rd, ram_wr_addr, ram_rd_addr, ram_din,
    input  ram_dout
  );

  modport slave (
    input  ram_wr, ram_rd, ram_wr_addr, ram_rd_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Sample delay line: writes each sample to a RAM ring and reads it back `offset` samples later.
// Optional DLY_FILL_MUTE_EN: track fill level and output 0 for slots not yet written since reset.
module delay_line_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  delay_line_ctrl_if.master        ram
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  logic [AW-1:0] wptr;
  logic          s1_valid;
  logic          zero_off_q;
  logic [DW-1:0] din_q;
  logic          mute;

  // RAM strobes and addresses follow en directly so the read lands one cycle later
  assign ram.ram_wr      = en;
  assign ram.ram_rd      = en;
  assign ram.ram_wr_addr = wptr;
  assign ram.ram_rd_addr = wptr - offset;
  assign ram.ram_din     = din;

`ifdef DLY_FILL_MUTE_EN
  typedef enum logic {FILL, RUN} state_t;

  localparam logic [AW-1:0] FILL_MAX = {AW{1'b1}};

  state_t        state;
  logic [AW-1:0] fill_cnt;

  // State doubles as the stage-1 mute flag: it is refreshed on every en from the pre-increment count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else if (en) begin
      state <= (fill_cnt >= offset) ? RUN : FILL;
      if (fill_cnt != FILL_MAX) begin
        fill_cnt <= fill_cnt + AW'(1);
      end
    end
  end

  assign mute = (state == FILL);
`else
  assign mute = 1'b0;
`endif

  // Stage 1 captures the sample context; stage 2 selects bypass, RAM word or mute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      s1_valid   <= 1'b0;
      zero_off_q <= 1'b0;
      din_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      s1_valid   <= en;
      dout_valid <= s1_valid;
      if (en) begin
        wptr       <= wptr + AW'(1);
        zero_off_q <= (offset == '0);
        din_q      <= din;
      end
      if (s1_valid) begin
        dout <= mute ? '0 : (zero_off_q ? din_q : ram.ram_dout);
      end
    end
  end

endmodule
